// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with per-slot dead time, frame-synchronous
// double buffering, per-digit blink and selectable output polarity.
module seg_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int CLK_DIV      = 100000,
    parameter int DEAD         = 1,
    parameter int BLINK_FRAMES = 64,
    parameter bit POL_LOW      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     dot_en,
    input  logic [DIGITS-1:0]     blink_en,
    output logic [DIGITS-1:0]     seg_en,
    output logic [7:0]            seg_out,
    output logic                  frame_done
);

    localparam int P_W = $clog2(CLK_DIV);
    localparam int S_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int F_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [P_W-1:0] P_LAST = P_W'(CLK_DIV - 1);
    localparam logic [P_W-1:0] P_DEAD = P_W'(DEAD);
    localparam logic [S_W-1:0] S_LAST = S_W'(DIGITS - 1);
    localparam logic [F_W-1:0] F_LAST = F_W'(BLINK_FRAMES - 1);

    logic [P_W-1:0] p, p_next;
    logic [S_W-1:0] slot, slot_next;
    logic [F_W-1:0] frame_cnt, frame_cnt_next;
    logic           phase, phase_next;
    logic           started;
    logic           boundary;

    logic [DIGITS-1:0][3:0] pend_digits, act_digits;
    logic [DIGITS-1:0]      pend_en, pend_dot, pend_blink;
    logic [DIGITS-1:0]      act_en, act_dot, act_blink;

    logic              lit;
    logic [DIGITS-1:0] en_d;
    logic [7:0]        seg_d;
    logic              fd_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            p         <= '0;
            slot      <= '0;
            frame_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            p         <= p_next;
            slot      <= slot_next;
            frame_cnt <= frame_cnt_next;
            phase     <= phase_next;
        end
    end

    // The blink counter only moves on the frame boundary, so blink is frame-locked.
    always_comb begin
        boundary       = (p == P_LAST) && (slot == S_LAST);
        p_next         = p + 1'b1;
        slot_next      = slot;
        frame_cnt_next = frame_cnt;
        phase_next     = phase;
        if (p == P_LAST) begin
            p_next    = '0;
            slot_next = (slot == S_LAST) ? '0 : slot + 1'b1;
        end
        if (boundary) begin
            if (frame_cnt == F_LAST) begin
                frame_cnt_next = '0;
                phase_next     = ~phase;
            end else begin
                frame_cnt_next = frame_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        lit   = act_en[slot] && (p >= P_DEAD) && (!act_blink[slot] || phase);
        en_d  = '0;
        seg_d = '0;
        if (lit) begin
            en_d[slot] = 1'b1;
            seg_d      = {act_dot[slot], decode(act_digits[slot])};
        end
        fd_d = started && (p == '0) && (slot == '0);
    end

    // Active takes the pre-edge pending value, so a load on the boundary waits a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_digits <= '0;
            pend_en     <= '0;
            pend_dot    <= '0;
            pend_blink  <= '0;
            act_digits  <= '0;
            act_en      <= '0;
            act_dot     <= '0;
            act_blink   <= '0;
            started     <= 1'b0;
            seg_en      <= {DIGITS{POL_LOW}};
            seg_out     <= {8{POL_LOW}};
            frame_done  <= 1'b0;
        end else begin
            if (boundary) begin
                act_digits <= pend_digits;
                act_en     <= pend_en;
                act_dot    <= pend_dot;
                act_blink  <= pend_blink;
                started    <= 1'b1;
            end
            if (load) begin
                pend_digits <= digits_in;
                pend_en     <= digit_en;
                pend_dot    <= dot_en;
                pend_blink  <= blink_en;
            end
            seg_en     <= en_d ^ {DIGITS{POL_LOW}};
            seg_out    <= seg_d ^ {8{POL_LOW}};
            frame_done <= fd_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: expected outputs are computed from
// elapsed cycles since reset and the load history, queued, then compared.
module tb_seg_scan_driver;

    localparam int DIGITS       = 8;
    localparam int CLK_DIV      = 4;
    localparam int DEAD         = 1;
    localparam int BLINK_FRAMES = 2;
    localparam bit POL_LOW      = 1'b1;
    localparam int FRAME        = DIGITS * CLK_DIV;

    localparam logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct packed {
        logic [31:0] dig;
        logic [7:0]  den;
        logic [7:0]  dot;
        logic [7:0]  blk;
    } buf_t;

    typedef struct packed {
        int   m;
        buf_t v;
    } load_t;

    typedef struct packed {
        logic [7:0] en;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] digits_in = '0;
    logic [7:0]  digit_en = '0;
    logic [7:0]  dot_en = '0;
    logic [7:0]  blink_en = '0;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic        frame_done;

    load_t hist[$];
    exp_t  sb[$];
    int    k = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    seg_scan_driver #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEAD(DEAD),
        .BLINK_FRAMES(BLINK_FRAMES), .POL_LOW(POL_LOW)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
        .digit_en(digit_en), .dot_en(dot_en), .blink_en(blink_en),
        .seg_en(seg_en), .seg_out(seg_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Output after edge kk shows the counter state reached kk-1 edges after reset.
    function automatic exp_t model(input int kk);
        exp_t e;
        buf_t a;
        int   s, p, i, f;
        logic ph, lit;
        e.en  = 8'hFF;
        e.seg = 8'hFF;
        e.fd  = 1'b0;
        if (kk < 1) return e;
        s = kk - 1;
        p = s % CLK_DIV;
        i = (s / CLK_DIV) % DIGITS;
        f = s / FRAME;
        a = '0;
        foreach (hist[j]) if (hist[j].m < FRAME * f) a = hist[j].v;
        ph  = ((f / BLINK_FRAMES) % 2) == 0;
        lit = a.den[i] && (p >= DEAD) && (!a.blk[i] || ph);
        if (lit) begin
            e.en  = ~(8'd1 << i);
            e.seg = ~{a.dot[i], SEG_TBL[a.dig[4*i +: 4]]};
        end
        e.fd = (s % FRAME == 0) && (s >= FRAME);
        return e;
    endfunction

    task automatic set_load(input logic [31:0] d, input logic [7:0] den,
                            input logic [7:0] dot, input logic [7:0] blk);
        load_t lv;
        digits_in = d;
        digit_en  = den;
        dot_en    = dot;
        blink_en  = blk;
        load      = 1'b1;
        lv.m      = k + 1;
        lv.v      = {d, den, dot, blk};
        hist.push_back(lv);
    endtask

    task automatic push_next();
        if (rst) sb.push_back(model(0));
        else     sb.push_back(model(k + 1));
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (rst) begin
            k = 0;
            hist.delete();
        end else begin
            k++;
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            push_next();
            advance();
            e = sb.pop_front();
            n_checks++;
            if ({seg_en, seg_out, frame_done} !== {e.en, e.seg, e.fd}) begin
                n_fail++;
                $display("[TB] FAIL reset k=%0d seg_en=%h/%h seg_out=%h/%h fd=%b/%b",
                         k, seg_en, e.en, seg_out, e.seg, frame_done, e.fd);
            end
            n_checks++;
            if ({seg_en, seg_out, frame_done} !== {8'hFF, 8'hFF, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL reset_const seg_en=%h seg_out=%h fd=%b, need FF FF 0",
                         seg_en, seg_out, frame_done);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            push_next();
            advance();
            e = sb.pop_front();
            n_checks++;
            if ({seg_en, seg_out, frame_done} !== {e.en, e.seg, e.fd}) begin
                n_fail++;
                $display("[TB] FAIL reset_blank k=%0d seg_en=%h/%h seg_out=%h/%h fd=%b/%b",
                         k, seg_en, e.en, seg_out, e.seg, frame_done, e.fd);
            end
        end
    endtask

    task automatic test_fives();
        exp_t e;
        int   fd_count = 0;
        for (int c = 0; c < 80; c++) begin
            if (c == 0) set_load(32'h5555_5555, 8'hFF, 8'h00, 8'h00);
            push_next();
            advance();
            e = sb.pop_front();
            n_checks++;
            if ({seg_en, seg_out, frame_done} !== {e.en, e.seg, e.fd}) begin
                n_fail++;
                $display("[TB] FAIL fives k=%0d seg_en=%h/%h seg_out=%h/%h fd=%b/%b",
                         k, seg_en, e.en, seg_out, e.seg, frame_done, e.fd);
            end
            if (e.en !== 8'hFF) begin
                n_checks++;
                if (seg_out !== 8'h92) begin
                    n_fail++;
                    $display("[TB] FAIL fives_seg k=%0d seg_out=%h, need 92", k, seg_out);
                end
            end
            n_checks++;
            if ($countones(~seg_en) > 1) begin
                n_fail++;
                $display("[TB] FAIL onehot k=%0d seg_en=%h, need at most one low bit", k, seg_en);
            end
            if (frame_done === 1'b1) fd_count++;
        end
        n_checks++;
        if (fd_count !== 3) begin
            n_fail++;
            $display("[TB] FAIL fd_count got %0d, need 3", fd_count);
        end
    endtask

    task automatic test_decode();
        exp_t       e;
        logic [3:0] nib;
        for (int v = 0; v < 16; v++) begin
            nib = 4'(v);
            for (int c = 0; c < FRAME; c++) begin
                if (c == 4) set_load({8{nib}}, 8'hFF, 8'h00, 8'h00);
                push_next();
                advance();
                e = sb.pop_front();
                n_checks++;
                if ({seg_en, seg_out, frame_done} !== {e.en, e.seg, e.fd}) begin
                    n_fail++;
                    $display("[TB] FAIL decode v=%0d k=%0d seg_en=%h/%h seg_out=%h/%h fd=%b/%b",
                             v, k, seg_en, e.en, seg_out, e.seg, frame_done, e.fd);
                end
            end
        end
    endtask

    task automatic test_masks();
        exp_t e;
        for (int c = 0; c < 96; c++) begin
            if (c == 0) set_load(32'h0000_0000, 8'hFB, 8'h02, 8'h00);
            push_next();
            advance();
            e = sb.pop_front();
            n_checks++;
            if ({seg_en, seg_out, frame_done} !== {e.en, e.seg, e.fd}) begin
                n_fail++;
                $display("[TB] FAIL masks k=%0d seg_en=%h/%h seg_out=%h/%h fd=%b/%b",
                         k, seg_en, e.en, seg_out, e.seg, frame_done, e.fd);
            end
            if (c >= 64) begin
                n_checks++;
                if (seg_en[2] !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL masks_slot2 k=%0d seg_en=%h, need bit2 high", k, seg_en);
                end
                if (seg_en === 8'hFD) begin
                    n_checks++;
                    if (seg_out !== 8'h40) begin
                        n_fail++;
                        $display("[TB] FAIL masks_dot k=%0d seg_out=%h, need 40", k, seg_out);
                    end
                end else if (seg_en !== 8'hFF) begin
                    n_checks++;
                    if (seg_out !== 8'hC0) begin
                        n_fail++;
                        $display("[TB] FAIL masks_zero k=%0d seg_out=%h, need C0", k, seg_out);
                    end
                end
            end
        end
    endtask

    task automatic test_blink();
        exp_t       e;
        int         s, f;
        logic [7:0] want;
        rst = 1'b1;
        push_next();
        advance();
        e = sb.pop_front();
        n_checks++;
        if ({seg_en, seg_out, frame_done} !== {e.en, e.seg, e.fd}) begin
            n_fail++;
            $display("[TB] FAIL blink_rst seg_en=%h/%h seg_out=%h/%h fd=%b/%b",
                     seg_en, e.en, seg_out, e.seg, frame_done, e.fd);
        end
        rst = 1'b0;
        for (int c = 0; c < 6 * FRAME + 2; c++) begin
            if (c == 2) set_load(32'h1111_1111, 8'hFF, 8'h00, 8'h08);
            push_next();
            advance();
            e = sb.pop_front();
            n_checks++;
            if ({seg_en, seg_out, frame_done} !== {e.en, e.seg, e.fd}) begin
                n_fail++;
                $display("[TB] FAIL blink k=%0d seg_en=%h/%h seg_out=%h/%h fd=%b/%b",
                         k, seg_en, e.en, seg_out, e.seg, frame_done, e.fd);
            end
            s = k - 1;
            f = s / FRAME;
            if (((s / CLK_DIV) % DIGITS == 3) && (s % CLK_DIV >= DEAD) && f >= 1 && f <= 5) begin
                want = (f == 2 || f == 3) ? 8'hFF : 8'hF7;
                n_checks++;
                if (seg_en !== want) begin
                    n_fail++;
                    $display("[TB] FAIL blink_slot3 frame=%0d seg_en=%h, need %h", f, seg_en, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   a_done = 0, b_done = 0, c_done = 0, d_done = 0;
        for (int c = 0; c < 240; c++) begin
            rst = 1'b0;
            if (!a_done && (k % FRAME) / CLK_DIV == 3) begin
                set_load(32'h7654_3210, 8'hFF, 8'h00, 8'h00);
                a_done = 1;
            end else if (c >= 64 && !b_done && (k + 1) % FRAME == 0) begin
                set_load(32'hFEDC_BA98, 8'hFF, 8'hAA, 8'h00);
                b_done = 1;
            end else if (c >= 128 && !c_done && (k % FRAME) / CLK_DIV == 5) begin
                rst = 1'b1;
                c_done = 1;
            end else if (c_done && !d_done && k == 2) begin
                set_load(32'h0123_4567, 8'hFF, 8'h0F, 8'h00);
                d_done = 1;
            end
            push_next();
            advance();
            e = sb.pop_front();
            n_checks++;
            if ({seg_en, seg_out, frame_done} !== {e.en, e.seg, e.fd}) begin
                n_fail++;
                $display("[TB] FAIL back_to_back k=%0d seg_en=%h/%h seg_out=%h/%h fd=%b/%b",
                         k, seg_en, e.en, seg_out, e.seg, frame_done, e.fd);
            end
        end
        rst = 1'b0;
        n_checks++;
        if (!(a_done && b_done && c_done && d_done)) begin
            n_fail++;
            $display("[TB] FAIL back_to_back_events got %b%b%b%b, need 1111",
                     a_done, b_done, c_done, d_done);
        end
    endtask

    initial begin
        test_reset();
        test_fives();
        test_decode();
        test_masks();
        test_blink();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
